// File: rtl/mt_regfile.sv
// mt_regfile -- multi-threaded register file with action injection and
// per-thread clear sweep.
//
// Storage is NUM_THREADS banks of 2**REGFILE_ADDR_WIDTH registers, addressed
// {thread, addr}. Two combinational read ports, one write port (wena), an
// action-inject port that writes the action word and mask of one bank, and a
// background sweep that zeroes one bank, one entry per free cycle.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   R1_thread_in/R1_addr_in           read port 1 select
//   R2_thread_in/R2_addr_in           read port 2 select
//   R1_data_out/R2_data_out           combinational read data
//   WR_thread_in/WR_addr_in           write port select
//   WR_data_in, wena                  write data and enable
//   action_data_in                    action field (NUM_ACTIONS bits)
//   action_thread_id_in, action_wen   action target bank and inject strobe
//   action_ready                      pending action buffer empty
//   action_overflow                   pulse: action dropped
//   clear_req, clear_thread_in        start sweep of a bank
//   clear_busy                        sweep in progress
//   clear_done                        pulse: last entry zeroed this cycle
module mt_regfile #(
   parameter int DATAPATH_WIDTH     = 64,
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int THREAD_BITS        = 2,
   parameter int NUM_ACTIONS        = 8,
   parameter int ACTION_REG         = 7,
   parameter int MASK_REG           = 6,
   parameter int BYPASS             = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [THREAD_BITS-1:0]        R1_thread_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_in,
   input  logic [THREAD_BITS-1:0]        R2_thread_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_in,
   input  logic [THREAD_BITS-1:0]        WR_thread_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
   input  logic [DATAPATH_WIDTH-1:0]     WR_data_in,
   input  logic                          wena,
   output logic [DATAPATH_WIDTH-1:0]     R1_data_out,
   output logic [DATAPATH_WIDTH-1:0]     R2_data_out,
   input  logic [NUM_ACTIONS-1:0]        action_data_in,
   input  logic [THREAD_BITS-1:0]        action_thread_id_in,
   input  logic                          action_wen,
   output logic                          action_ready,
   output logic                          action_overflow,
   input  logic                          clear_req,
   input  logic [THREAD_BITS-1:0]        clear_thread_in,
   output logic                          clear_busy,
   output logic                          clear_done
);

   localparam int IDX_W   = THREAD_BITS + REGFILE_ADDR_WIDTH;
   localparam int ENTRIES = 2 ** IDX_W;

   localparam logic [REGFILE_ADDR_WIDTH-1:0] ACT_IDX  = REGFILE_ADDR_WIDTH'(ACTION_REG);
   localparam logic [REGFILE_ADDR_WIDTH-1:0] MASK_IDX = REGFILE_ADDR_WIDTH'(MASK_REG);
   localparam logic [DATAPATH_WIDTH-1:0] MASK_VAL =
      {{NUM_ACTIONS{1'b0}}, {(DATAPATH_WIDTH-NUM_ACTIONS){1'b1}}};

   typedef enum logic {IDLE, CLEAR} state_t;

   logic [DATAPATH_WIDTH-1:0] mem [ENTRIES];

   logic [IDX_W-1:0] r1_idx, r2_idx, wr_idx;
   assign r1_idx = {R1_thread_in, R1_addr_in};
   assign r2_idx = {R2_thread_in, R2_addr_in};
   assign wr_idx = {WR_thread_in, WR_addr_in};

   // One-entry pending action buffer
   logic                   pend_valid;
   logic [THREAD_BITS-1:0] pend_thread;
   logic [NUM_ACTIONS-1:0] pend_data;

   logic                   drain, apply_now, act_go, capture, drop;
   logic [THREAD_BITS-1:0] act_thread;
   logic [NUM_ACTIONS-1:0] act_data;

   // The buffered action drains on the first cycle the write port is free;
   // a fresh action only goes straight in when nothing is queued ahead of it.
   assign drain     = pend_valid && !wena;
   assign apply_now = action_wen && !wena && !pend_valid;
   assign act_go    = drain || apply_now;
   // A new action is queued if the write port is busy and the slot is free,
   // or if the slot is being vacated this very cycle.
   assign capture   = action_wen && (wena ? !pend_valid : pend_valid);
   assign drop      = action_wen && wena && pend_valid;

   assign act_thread = drain ? pend_thread : action_thread_id_in;
   assign act_data   = drain ? pend_data   : action_data_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid <= 1'b0;
      end else if (capture) begin
         pend_valid <= 1'b1;
      end else if (drain) begin
         pend_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         pend_thread <= action_thread_id_in;
         pend_data   <= action_data_in;
      end
   end

   // Clear sweep FSM
   state_t                        state, state_nxt;
   logic [REGFILE_ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic [THREAD_BITS-1:0]        clr_thread, clr_thread_nxt;
   logic                          sweep_go, sweep_last;

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      clr_thread_nxt = clr_thread;
      sweep_go       = 1'b0;
      sweep_last     = 1'b0;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_nxt      = CLEAR;
               cnt_nxt        = '0;
               clr_thread_nxt = clear_thread_in;
            end
         end
         CLEAR: begin
            // Sweep only takes the write slot when wena and actions leave it free.
            if (!wena && !act_go) begin
               sweep_go = 1'b1;
               if (cnt == '1) begin
                  sweep_last = 1'b1;
                  state_nxt  = IDLE;
                  cnt_nxt    = '0;
               end else begin
                  cnt_nxt = cnt + REGFILE_ADDR_WIDTH'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      clr_thread <= clr_thread_nxt;
   end

   // Single-writer storage update, highest priority first
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i] <= '0;
         end
      end else if (wena) begin
         mem[wr_idx] <= WR_data_in;
      end else if (act_go) begin
         mem[{act_thread, ACT_IDX}]  <= {act_data, {(DATAPATH_WIDTH-NUM_ACTIONS){1'b0}}};
         mem[{act_thread, MASK_IDX}] <= MASK_VAL;
      end else if (sweep_go) begin
         mem[{clr_thread, cnt}] <= '0;
      end
   end

   // Reads: forwarding only from the wena port; reset forces stored data to 0
   // for the cycle in which the array is being cleared.
   always_comb begin
      R1_data_out = reset ? '0 : mem[r1_idx];
      if (BYPASS != 0 && wena && r1_idx == wr_idx) begin
         R1_data_out = WR_data_in;
      end
   end

   always_comb begin
      R2_data_out = reset ? '0 : mem[r2_idx];
      if (BYPASS != 0 && wena && r2_idx == wr_idx) begin
         R2_data_out = WR_data_in;
      end
   end

   assign action_ready    = !pend_valid || reset;
   assign action_overflow = drop && !reset;
   assign clear_busy      = (state == CLEAR) && !reset;
   assign clear_done      = sweep_last && !reset;

endmodule
